// File: rtl/div4_seq_ctrl_pkg.sv
// Shared definitions for the 4-bit by 2-bit sequential restoring divider.
// Holds the controller state encoding, datapath widths and the fixed
// start-to-done latency.
package div4_seq_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DIVIDEND_W = 4;
  localparam int DIVISOR_W  = 2;
  localparam int REM_W      = 3;
  localparam int CNT_W      = 2;

  // Cycles from the accepting clock edge to the cycle in which done is high.
  localparam int DONE_LATENCY = 5;

  // Counter value loaded on start: index of the dividend MSB.
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DIVIDEND_W - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

endpackage

// File: rtl/div4_seq_ctrl_div_step.sv
// One restoring division step (purely combinational).
// Ports:
//   pr      - current partial remainder
//   bit_in  - next dividend bit, MSB first
//   divisor - unsigned divisor
//   pr_next - partial remainder after shift-in and conditional subtract
//   q_bit   - quotient bit produced by this step
module div_step
  import div4_seq_ctrl_pkg::*;
(
  input  logic [REM_W-1:0]     pr,
  input  logic                 bit_in,
  input  logic [DIVISOR_W-1:0] divisor,
  output logic [REM_W-1:0]     pr_next,
  output logic                 q_bit
);

  logic [REM_W-1:0] w_shift;
  logic [REM_W-1:0] w_div_ext;

  assign w_shift   = {pr[REM_W-2:0], bit_in};
  assign w_div_ext = {1'b0, divisor};

  always_comb begin
    pr_next = w_shift;
    q_bit   = 1'b0;
    if (w_shift >= w_div_ext) begin
      pr_next = w_shift - w_div_ext;
      q_bit   = 1'b1;
    end
  end

endmodule

// File: rtl/div4_seq_ctrl.sv
// Sequential 4-bit / 2-bit unsigned restoring divider with a small
// IDLE -> RUN -> DONE controller. A single div_step instance is reused for
// the four RUN cycles, the counter selecting which dividend bit feeds it.
// Ports:
//   clk, rst     - clock, asynchronous active-high reset
//   start        - request a division (only looked at in IDLE)
//   dividend     - 4-bit unsigned dividend, captured on acceptance
//   divisor      - 2-bit unsigned divisor, captured on acceptance
//   busy         - high while in RUN and DONE
//   done         - one-cycle pulse, results valid from this cycle on
//   quotient     - registered quotient (4'hF on divide by zero)
//   remainder    - registered remainder (0 on divide by zero)
//   div_by_zero  - registered divide-by-zero flag
module div4_seq_ctrl
  import div4_seq_ctrl_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic                  busy,
  output logic                  done,
  output logic [DIVIDEND_W-1:0] quotient,
  output logic [REM_W-1:0]      remainder,
  output logic                  div_by_zero
);

  state_t                  r_state;
  logic [DIVIDEND_W-1:0]   r_dividend;
  logic [DIVISOR_W-1:0]    r_divisor;
  logic [REM_W-1:0]        r_pr;
  // Only the first three quotient bits need storing; the fourth comes
  // straight from the step on the final RUN cycle.
  logic [DIVIDEND_W-2:0]   r_q;
  logic [CNT_W-1:0]        r_cnt;

  logic [REM_W-1:0]        w_pr_next;
  logic                    w_q_bit;
  logic                    w_div_zero;

  div_step u_step (
    .pr      (r_pr),
    .bit_in  (r_dividend[r_cnt]),
    .divisor (r_divisor),
    .pr_next (w_pr_next),
    .q_bit   (w_q_bit)
  );

  assign w_div_zero = (r_divisor == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_dividend  <= '0;
      r_divisor   <= '0;
      r_pr        <= '0;
      r_q         <= '0;
      r_cnt       <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_dividend <= dividend;
            r_divisor  <= divisor;
            r_pr       <= '0;
            r_q        <= '0;
            r_cnt      <= CNT_LOAD;
            busy       <= 1'b1;
            r_state    <= RUN;
          end
        end

        RUN: begin
          r_pr  <= w_pr_next;
          r_q   <= {r_q[DIVIDEND_W-3:0], w_q_bit};
          r_cnt <= r_cnt - CNT_ONE;
          // Results are published only on the last step so the outputs
          // stay frozen at the previous result throughout RUN.
          if (r_cnt == '0) begin
            r_state     <= DONE;
            done        <= 1'b1;
            div_by_zero <= w_div_zero;
            quotient    <= w_div_zero ? {DIVIDEND_W{1'b1}} : {r_q, w_q_bit};
            remainder   <= w_div_zero ? '0 : w_pr_next;
          end
        end

        DONE: begin
          // start is deliberately not looked at here; a held start is
          // picked up in the following IDLE cycle.
          done    <= 1'b0;
          busy    <= 1'b0;
          r_state <= IDLE;
        end

        default: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/div4_seq_ctrl.md
DIV4_SEQ_CTRL -- requirements
Module: div4_seq_ctrl

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-003 SHALL have port start, input, 1 bit: request a division; sampled only in IDLE.
REQ-004 SHALL have port dividend, input, 4 bits: unsigned dividend; captured when start is accepted.
REQ-005 SHALL have port divisor, input, 2 bits: unsigned divisor; captured when start is accepted.
REQ-006 SHALL have port busy, output, 1 bit: high in RUN and DONE.
REQ-007 SHALL have port done, output, 1 bit: one-cycle pulse when results become valid.
REQ-008 SHALL have port quotient, output, 4 bits: registered quotient.
REQ-009 SHALL have port remainder, output, 3 bits: registered remainder; bit 2 is always 0.
REQ-010 SHALL have port div_by_zero, output, 1 bit: registered flag for divisor == 0.

Function
REQ-011 SHALL implement FSM IDLE -> RUN -> DONE -> IDLE.
REQ-012 In IDLE with start=1, SHALL latch dividend/divisor, clear the partial remainder to 3'b000 and the quotient shift register, load step counter = 3, and enter RUN.
REQ-013 In RUN, SHALL perform one restoring step per cycle, MSB first, using dividend bit [counter]:
- pr' = {pr[1:0], bit}
- if pr' >= {1'b0, divisor}: pr' -= divisor and q bit = 1
- else: q bit = 0
REQ-014 SHALL decrement the counter each RUN cycle and leave RUN for DONE after the step with counter = 0, giving exactly 4 RUN cycles.
REQ-015 SHALL update the quotient, remainder and div_by_zero outputs and assert done in the single DONE cycle; if start is accepted at edge N, done is high in cycle N+5.
REQ-016 SHALL hold the outputs stable after DONE until the next accepted start reaches DONE; they SHALL NOT change during RUN.
REQ-017 SHALL ignore start in RUN and DONE, with no queuing; start held high through DONE is accepted in the following IDLE cycle.
REQ-018 SHALL NOT sample dividend/divisor changes after acceptance.
REQ-019 On divisor == 0, SHALL still take the full fixed latency and produce quotient 4'hF, remainder 3'b000 and div_by_zero 1.
REQ-020 For divisor != 0, SHALL produce div_by_zero 0, with quotient*divisor + remainder == dividend and remainder < divisor.
REQ-021 The partial remainder SHALL never exceed 3'd5, so 3 bits are sufficient and no overflow is possible.

Reset
REQ-022 rst SHALL force IDLE and clear busy, done, quotient, remainder, div_by_zero, the counter and all internal registers to 0, immediately and regardless of clk.
REQ-023 Reset during RUN or DONE SHALL abort the operation with no done pulse; the first start after rst deasserts SHALL be serviced normally.

Structure
REQ-024 A shared package SHALL hold:
- the FSM state enumeration (IDLE, RUN, DONE)
- width constants: DIVIDEND_W = 4, DIVISOR_W = 2, REM_W = 3, CNT_W = 2
- the DONE latency constant, 5
REQ-025 One restoring step SHALL be a combinational sub-module div_step:
- inputs: pr[2:0], dividend bit, divisor[1:0]
- outputs: pr_next[2:0], q_bit
REQ-026 div_step SHALL be instantiated once and time-shared across the four RUN cycles under counter control.

Verification
REQ-027 13 / 3, start pulsed at edge 0 -> busy high in cycles 1-5; done high only in cycle 5; quotient 4, remainder 1, div_by_zero 0.
REQ-028 15 / 1 -> quotient 15, remainder 0; also 2 / 3 -> quotient 0, remainder 2.
REQ-029 9 / 0 -> done at the same latency; quotient 4'hF, remainder 0, div_by_zero 1.
REQ-030 Start 13 / 3, then start with 7 / 2 and dividend changes in cycles 1-4 -> only the 13 / 3 result appears, with a single done pulse.
REQ-031 Assert rst in cycle 3 of a run -> all outputs 0 immediately and no done pulse; a following 6 / 2 -> quotient 3, remainder 0.
REQ-032 Exhaustive sweep, all 64 dividend/divisor pairs run back to back -> every result matches the reference arithmetic and its div_by_zero flag.
